// File: rtl/rc5_key_scheduler.sv
// rc5_key_scheduler: parametrised RC5 key expansion with internal key, L and S stores.
// One array operation per cycle; the S table is exposed through a registered read port.
module rc5_key_scheduler #(
  parameter int unsigned  W     = 32,
  parameter int unsigned  R     = 12,
  parameter int unsigned  B_MAX = 16,
  parameter logic [W-1:0] PW    = 32'hB7E15163,
  parameter logic [W-1:0] QW    = 32'h9E3779B9,
  localparam int unsigned T     = 2*(R+1),
  localparam int unsigned C_MAX = ((8*B_MAX + W - 1)/W > 1) ? (8*B_MAX + W - 1)/W : 1,
  localparam int unsigned KAW   = (B_MAX > 1) ? $clog2(B_MAX) : 1,
  localparam int unsigned KLW   = $clog2(B_MAX+1),
  localparam int unsigned TAW   = $clog2(T)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_we,
  input  logic [KAW-1:0] key_addr,
  input  logic [7:0]     key_data,
  input  logic [KLW-1:0] key_len,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           len_err,
  input  logic [TAW-1:0] s_rd_addr,
  output logic [W-1:0]   s_rd_data
);
  localparam int unsigned U   = W/8;
  localparam int unsigned LGU = $clog2(U);
  localparam int unsigned LGW = $clog2(W);
  localparam int unsigned LAW = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  typedef enum logic [2:0] {IDLE, CLR, PACK, INIT, MIX, FIN} state_t;
  state_t state, state_nx;

  logic [7:0]     key_mem [B_MAX];
  logic [W-1:0]   l_mem   [C_MAX];
  logic [W-1:0]   s_mem   [T];

  logic [KLW-1:0] b_len;
  logic [31:0]    cnt, limit, c_words, n_mix;
  logic [TAW-1:0] i_idx;
  logic [LAW-1:0] j_idx;
  logic [W-1:0]   a_reg, b_reg, rd_q;
  logic           last, len_bad, j_last;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] r);
    return W'(({x, x} << r) >> W);
  endfunction

  assign busy      = (state != IDLE);
  assign s_rd_data = busy ? '0 : rd_q;
  assign len_bad   = (32'(key_len) > B_MAX);

  // c = max(1, ceil(b/u)); mixing runs 3*max(T,c) steps
  always_comb begin
    c_words = (32'(b_len) + U - 1) >> LGU;
    if (c_words == 32'd0) c_words = 32'd1;
    n_mix = 32'd3 * ((c_words > T) ? c_words : T);
  end

  always_comb begin
    limit = 32'd1;
    case (state)
      CLR:     limit = C_MAX;
      PACK:    limit = 32'(b_len);
      INIT:    limit = T;
      MIX:     limit = n_mix;
      default: limit = 32'd1;
    endcase
  end

  assign last   = (cnt == limit - 32'd1);
  assign j_last = (32'(j_idx) == c_words - 32'd1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !len_bad) state_nx = CLR;
      CLR:     if (last) state_nx = (b_len == '0) ? INIT : PACK;
      PACK:    if (last) state_nx = INIT;
      INIT:    if (last) state_nx = MIX;
      MIX:     if (last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // PACK walks key bytes from b-1 down to 0
  logic [KAW-1:0] pk_byte;
  logic [LAW-1:0] pk_word;
  assign pk_byte = KAW'(32'(b_len) - 32'd1 - cnt);
  assign pk_word = LAW'((32'(b_len) - 32'd1 - cnt) >> LGU);

  logic [W-1:0] a_new, b_new;
  assign a_new = rotl(s_mem[i_idx] + a_reg + b_reg, LGW'(3));
  assign b_new = rotl(l_mem[j_idx] + a_new + b_reg, LGW'(a_new + b_reg));

  logic           l_we, s_we;
  logic [LAW-1:0] l_wa;
  logic [TAW-1:0] s_wa;
  logic [W-1:0]   l_wd, s_wd;

  always_comb begin
    l_we = 1'b0; l_wa = '0; l_wd = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0;
    case (state)
      CLR:  begin l_we = 1'b1; l_wa = cnt[LAW-1:0]; end
      PACK: begin
        l_we = 1'b1; l_wa = pk_word;
        l_wd = {l_mem[pk_word][W-9:0], key_mem[pk_byte]};
      end
      INIT: begin s_we = 1'b1; s_wa = cnt[TAW-1:0]; s_wd = a_reg; end
      MIX:  begin
        s_we = 1'b1; s_wa = i_idx; s_wd = a_new;
        l_we = 1'b1; l_wa = j_idx; l_wd = b_new;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (l_we) l_mem[l_wa] <= l_wd;
    if (s_we) s_mem[s_wa] <= s_wd;
    if (key_we && !busy && (32'(key_addr) < B_MAX)) key_mem[key_addr] <= key_data;
  end

  // a_reg doubles as the S[k] accumulator during INIT and is zeroed for MIX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      b_len   <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      done    <= 1'b0;
      len_err <= 1'b0;
      rd_q    <= '0;
    end else begin
      state <= state_nx;
      rd_q  <= (32'(s_rd_addr) < T) ? s_mem[s_rd_addr] : '0;
      cnt   <= (state == IDLE || last) ? '0 : cnt + 32'd1;
      case (state)
        IDLE: if (start) begin
          b_len   <= key_len;
          done    <= 1'b0;
          len_err <= len_bad;
          a_reg   <= PW;
        end
        INIT: begin
          a_reg <= last ? '0 : a_reg + QW;
          if (last) begin
            b_reg <= '0;
            i_idx <= '0;
            j_idx <= '0;
          end
        end
        MIX: begin
          a_reg <= a_new;
          b_reg <= b_new;
          i_idx <= (32'(i_idx) == T - 1) ? '0 : i_idx + TAW'(1);
          j_idx <= j_last ? '0 : j_idx + LAW'(1);
        end
        FIN:     done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rc5_key_scheduler.sv
// Bench for rc5_key_scheduler: a 32-bit and a 16-bit instance, random keys,
// scoreboard of expected latency and S tables checked by an independent monitor.
module tb_rc5_key_scheduler;
  typedef struct packed {
    logic [31:0] dut;
    logic [31:0] lat;
    logic [31:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0, checked = 0, req = 0, served = 0, req_d = 0;

  int          start_v [2];
  int          kwe     [2];
  int          kaddr   [2];
  int          kdata   [2];
  int          klen    [2];
  int          rd_addr [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        lerr_o  [2];
  logic [63:0] rd_o    [2];
  logic [31:0] s32;
  logic [15:0] s16;

  logic [7:0]      kimg [2][16];
  longint unsigned exp_tab [26];
  exp_t            sb_q [$];
  longint unsigned sb_s [$];

  assign rd_o[0] = 64'(s32);
  assign rd_o[1] = 64'(s16);

  rc5_key_scheduler #(.W(32), .R(12), .B_MAX(16), .PW(32'hB7E15163), .QW(32'h9E3779B9)) dut32 (
    .clk(clk), .rst(rst),
    .key_we(kwe[0] != 0), .key_addr(4'(kaddr[0])), .key_data(8'(kdata[0])),
    .key_len(5'(klen[0])), .start(start_v[0] != 0),
    .busy(busy_o[0]), .done(done_o[0]), .len_err(lerr_o[0]),
    .s_rd_addr(5'(rd_addr[0])), .s_rd_data(s32)
  );

  rc5_key_scheduler #(.W(16), .R(12), .B_MAX(8), .PW(16'hB7E1), .QW(16'h9E37)) dut16 (
    .clk(clk), .rst(rst),
    .key_we(kwe[1] != 0), .key_addr(3'(kaddr[1])), .key_data(8'(kdata[1])),
    .key_len(4'(klen[1])), .start(start_v[1] != 0),
    .busy(busy_o[1]), .done(done_o[1]), .len_err(lerr_o[1]),
    .s_rd_addr(5'(rd_addr[1])), .s_rd_data(s16)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic longint unsigned rotl_ref(input longint unsigned x, input int n, input int w,
                                               input longint unsigned m);
    if (n == 0) return x;
    return ((x << n) | (x >> (w - n))) & m;
  endfunction

  // Textbook RC5 key expansion on the bench's copy of the key
  function automatic void model(input int d, input int b);
    int w, u, c, ii, jj;
    longint unsigned m, a, bb, q;
    longint unsigned l [16];
    w = (d == 0) ? 32 : 16;
    u = w / 8;
    m = (64'd1 << w) - 1;
    c = (b + u - 1) / u;
    if (c == 0) c = 1;
    foreach (l[k]) l[k] = 0;
    for (int i = b - 1; i >= 0; i--) l[i/u] = ((l[i/u] << 8) + 64'(kimg[d][i])) & m;
    exp_tab[0] = (d == 0) ? 64'hB7E15163 : 64'hB7E1;
    q = (d == 0) ? 64'h9E3779B9 : 64'h9E37;
    for (int k = 1; k < 26; k++) exp_tab[k] = (exp_tab[k-1] + q) & m;
    a = 0; bb = 0; ii = 0; jj = 0;
    for (int n = 0; n < 3 * imax(26, c); n++) begin
      a = rotl_ref((exp_tab[ii] + a + bb) & m, 3, w, m);
      exp_tab[ii] = a;
      bb = rotl_ref((l[jj] + a + bb) & m, int'((a + bb) % 64'(w)), w, m);
      l[jj] = bb;
      ii = (ii + 1) % 26;
      jj = (jj + 1) % c;
    end
  endfunction

  task automatic push_tab();
    for (int k = 0; k < 26; k++) sb_s.push_back(exp_tab[k]);
  endtask

  task automatic wait_mon();
    int n = 0;
    while ((checked != pushed || served != req) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (checked != pushed || served != req) begin
      errors++; checks++;
      $display("FAIL mon_timeout: runs checked %0d of %0d, sweeps %0d of %0d", checked, pushed, served, req);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
    end
  endtask

  task automatic wr(input int d, input int a, input int v);
    @(negedge clk);
    kwe[d] = 1; kaddr[d] = a; kdata[d] = v;
    @(negedge clk);
    kwe[d] = 0;
  endtask

  task automatic load_key(input int d);
    for (int i = 0; i < ((d == 0) ? 16 : 8); i++) begin
      kimg[d][i] = 8'($urandom);
      wr(d, i, int'(kimg[d][i]));
    end
  endtask

  task automatic run(input int d, input int b, input bit newkey, input bit glitch, input bit samewr);
    exp_t e;
    int   u, c;
    if (newkey) load_key(d);
    @(negedge clk);
    start_v[d] = 1; klen[d] = b;
    if (samewr) begin
      kwe[d] = 1; kaddr[d] = 0; kdata[d] = 8'hA5; kimg[d][0] = 8'hA5;
    end
    @(negedge clk);
    start_v[d] = 0; kwe[d] = 0;
    chk("busy_after_start", busy_o[d], 1);
    chk("len_err_cleared", lerr_o[d], 0);
    chk("done_cleared", done_o[d], 0);
    u = (d == 0) ? 4 : 2;
    c = imax(1, (b + u - 1) / u);
    e.dut = 32'(d);
    e.st  = 32'(cyc);
    e.lat = 32'(4 + b + 26 + 3 * imax(26, c) + 1);
    model(d, b);
    push_tab();
    sb_q.push_back(e);
    pushed++;
    if (glitch) begin
      @(negedge clk);
      start_v[d] = 1; kwe[d] = 1; kaddr[d] = 3; kdata[d] = 8'hFF;
      @(negedge clk);
      start_v[d] = 0; kwe[d] = 0;
    end
    wait_mon();
    chk("done_holds", done_o[d], 1);
  endtask

  task automatic sweep(input int d);
    longint unsigned ex;
    for (int a = 0; a < 32; a++) begin
      rd_addr[d] = a;
      @(negedge clk);
      ex = 0;
      if (a < 26) begin
        if (sb_s.size() > 0) ex = sb_s.pop_front();
        else begin errors++; $display("FAIL sb_empty: no expected word for S%0d", a); end
      end
      chk($sformatf("dut%0d_S%0d", d, a), rd_o[d], ex);
    end
    rd_addr[d] = 0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   dprev [2];
    bit   nzb   [2];
    rd_addr[0] = 0; rd_addr[1] = 0;
    dprev[0] = 0; dprev[1] = 0; nzb[0] = 0; nzb[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (busy_o[d] && rd_o[d] != 0) nzb[d] = 1;
        if (done_o[d] && !dprev[d]) begin
          if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_done: dut%0d raised done with no run pending", d);
          end else begin
            e = sb_q.pop_front();
            chk("done_dut", longint'(d), longint'(e.dut));
            chk($sformatf("dut%0d_latency", d), longint'(cyc - int'(e.st)), longint'(e.lat));
            chk("busy_low_at_done", busy_o[d], 0);
            chk("rd_zero_while_busy", nzb[d], 0);
            nzb[d] = 0;
            sweep(d);
            checked++;
          end
        end
        dprev[d] = done_o[d];
      end
      if (served != req) begin
        sweep(req_d);
        served++;
      end
    end
  end

  initial begin : stim
    bit bz;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 0; kwe[d] = 0; kaddr[d] = 0; kdata[d] = 0; klen[d] = 0;
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy_o[d], 0);
      chk("rst_done", done_o[d], 0);
      chk("rst_len_err", lerr_o[d], 0);
      chk("rst_rd_data", rd_o[d], 0);
    end
    @(negedge clk) rst = 1'b1;

    run(0, 16, 1, 0, 0);

    // abort mid-MIX, then restart the same key
    load_key(0);
    @(negedge clk); start_v[0] = 1; klen[0] = 16;
    @(negedge clk); start_v[0] = 0;
    repeat (59) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy_o[0], 0);
    chk("abort_done", done_o[0], 0);
    @(negedge clk) rst = 1'b1;
    run(0, 16, 0, 0, 0);

    run(0, 0, 1, 0, 0);

    // over-length key: flagged, no run, S untouched
    @(negedge clk); start_v[0] = 1; klen[0] = 17;
    @(negedge clk); start_v[0] = 0;
    chk("len_err_set", lerr_o[0], 1);
    chk("len_err_busy", busy_o[0], 0);
    chk("len_err_done", done_o[0], 0);
    bz = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o[0]) bz = 1;
    end
    chk("len_err_busy_never", bz, 0);
    chk("len_err_held", lerr_o[0], 1);
    push_tab();
    req_d = 0;
    req++;
    wait_mon();

    run(0, 16, 1, 1, 0);
    run(0, 16, 0, 0, 0);
    run(0, 16, 1, 0, 1);

    run(1, 5, 1, 0, 0);
    run(1, 8, 1, 0, 1);

    for (int r = 0; r < 3; r++) begin
      run(0, $urandom_range(0, 16), 1, 0, 0);
      run(1, $urandom_range(0, 8), 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rc5_key_scheduler.md
Name: rc5_key_scheduler

Overview:
- Parametrised RC5 key-schedule engine. It replaces the fixed W/B/R key-expander top and its three external RAMs.
- It owns the key byte store, the L array and the S table internally.
- It accepts a runtime key length, runs a start/busy/done handshake, and flags invalid lengths.
- It exposes a registered S-table read port for the downstream RC5 encrypt/decrypt datapath.

Parameters:
- W, 32, word width in bits; legal values 16, 32, 64.
- R, 12, round count; T = 2*(R+1) S words.
- B_MAX, 16, maximum key length in bytes (>=1); C_MAX = max(1, ceil(8*B_MAX/W)).
- PW, 32'hB7E15163, magic constant P, W bits wide.
- QW, 32'h9E3779B9, magic constant Q, W bits wide.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- key_we  in  1  key byte write strobe.
- key_addr  in  clog2(B_MAX)  key byte index.
- key_data  in  8  key byte.
- key_len  in  clog2(B_MAX+1)  key length b, sampled on start.
- start  in  1  single-cycle request to expand the stored key.
- busy  out  1  expansion in progress.
- done  out  1  S table valid.
- len_err  out  1  last start had key_len > B_MAX.
- s_rd_addr  in  clog2(T)  S table read index.
- s_rd_data  out  W  registered S[s_rd_addr].

Behaviour:
- Reset (rst=0, async):
  - busy=0, done=0, len_err=0, s_rd_data=0.
  - A=B=0, all indices 0, FSM to IDLE.
  - Key, L and S array contents are not reset.
  - Reset during any state aborts expansion; done stays 0 until a full run completes.
- key_we is honoured only when busy=0; it writes key[key_addr] at the edge. Writes while busy are dropped.
- start is honoured only when busy=0; while busy it is ignored.
  - On an accepted start: capture b=key_len, clear done and len_err.
  - If b > B_MAX: set len_err=1 at that edge, stay IDLE, busy stays 0.
  - Otherwise set busy=1 at that edge and go to CLR.
- Derived values: u=W/8, c = max(1, ceil(b/u)), N = 3*max(T,c).
- FSM, one array operation per cycle:
  - IDLE: wait for start.
  - CLR: L[j]=0 for j=0..C_MAX-1; C_MAX cycles.
  - PACK: i = b-1 down to 0, L[i/u] = (L[i/u]<<8) + key[i]; b cycles. Skipped when b=0.
  - INIT: S[0]=PW, then S[k] = S[k-1] + QW (mod 2^W), k=1..T-1; T cycles.
  - MIX: i=j=0, A=B=0; N cycles. Each cycle:
    - A' = (S[i]+A+B) <<< 3; S[i] = A'.
    - B' = (L[j]+A'+B) <<< ((A'+B) mod W); L[j] = B'.
    - A=A', B=B'; i=(i+1) mod T, j=(j+1) mod c.
  - DONE: entered at the last MIX edge; busy=0, done=1. done holds until the next accepted start or reset.
- Arithmetic: all additions are modulo 2^W. The rotate amount uses only the low log2(W) bits.
- Latency: Lc = C_MAX + b + T + N. If start is sampled at edge k, done=1 and busy=0 after edge k+Lc+1.
- S read port: s_rd_data is registered with 1-cycle latency; s_rd_data = S[s_rd_addr] sampled at the previous edge.
  - Forced to 0 while busy=1.
  - Out-of-range s_rd_addr (>=T) returns 0.
- Restart: start while done=1 is legal and re-runs with the current key and key_len.
- Simultaneous key_we and start in the same cycle with busy=0: the write lands first, so the new byte is used in PACK.

Test Plan:
- Reset mid-MIX:
  - Stimulus: W=32, R=12, B_MAX=16; load 16 bytes; start; pull rst low at cycle 60.
  - Response: busy=done=0 immediately.
  - Then release rst and restart. Response: done rises exactly 125 edges after the start edge (4+16+26+78=124, +1).
- Zero-length key:
  - Stimulus: key_len=0; start.
  - Response: done after 109 edges; S[0..25] match the golden C model for an empty key. Read S[0] via s_rd_addr=0 and see data one cycle later.
- Length error:
  - Stimulus: key_len=17, start.
  - Response: len_err=1 next cycle, busy never rises, done=0, S unchanged.
- Ignored inputs while busy:
  - Stimulus: during busy, pulse start and key_we with addr 3, data 0xFF.
  - Response: latency unchanged, key[3] unchanged, final S equals the no-glitch run.
- Same-cycle write and start:
  - Stimulus: key_we (addr 0, data 0xA5) in the same cycle as start.
  - Response: the result equals a model run with key[0]=0xA5.
- Width generalisation:
  - Stimulus: W=16, R=12, B_MAX=8, PW=16'hB7E1, QW=16'h9E37; key_len=5 (c=3); run.
  - Response: done after 1+4+5+26+78=114 edges; S matches the RC5-16/12/5 model. Rotate uses the low 4 bits.
